// File: rtl/ethernet_mmio_tx_initiator.sv
// Host-side MMIO initiator: polls TX ready, fills the TX buffer, writes length, sends, clears pending.
// Optional ETH_MMIO_TX_INIT_IRQ_EN: enables the TX event and waits on tx_irq_i instead of polling pending.
module ethernet_mmio_tx_initiator #(
  parameter int eth_mtu_p    = 2048,
  parameter int data_width_p = 32,
  parameter int poll_gap_p   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    pkt_v_i,
  output logic                    pkt_ready_o,
  input  logic [31:0]             pkt_data_i,
  input  logic                    pkt_last_i,
  input  logic [1:0]              pkt_bytes_i,
  output logic [13:0]             addr_o,
  output logic                    write_en_o,
  output logic                    read_en_o,
  output logic [1:0]              op_size_o,
  output logic [data_width_p-1:0] write_data_o,
  input  logic [data_width_p-1:0] read_data_i,
  input  logic                    io_decode_error_i,
  input  logic                    tx_irq_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o
);

  // state     | meaning
  // IDLE      | waiting for the first packet word
  // RDY_RD    | read TX ready status (0x101C)
  // RDY_CHK   | test ready bit 0 in the returned data
  // RDY_WAIT  | gap between ready polls
  // EN_IRQ    | enable TX event (0x1034), irq build only
  // DATA      | accept words, write TX buffer (0x0800+)
  // DATA_TAIL | write byte 2 of a 3-byte last word
  // LEN       | write byte count (0x1028)
  // SEND      | trigger send (0x1018)
  // PEND_RD   | read TX event pending (0x1030)
  // PEND_CHK  | test pending bit 0
  // PEND_WAIT | gap between pending polls
  // WAIT_IRQ  | wait for tx_irq_i, irq build only
  // CLR       | clear pending (0x1030), pulse done
  // DROP      | drain the rest of an aborted packet
  typedef enum logic [3:0] {
    IDLE, RDY_RD, RDY_CHK, RDY_WAIT, EN_IRQ, DATA, DATA_TAIL, LEN,
    SEND, PEND_RD, PEND_CHK, PEND_WAIT, WAIT_IRQ, CLR, DROP
  } state_e;

  localparam int cnt_w_lp  = $clog2(eth_mtu_p + 1);
  localparam int poll_w_lp = (poll_gap_p > 1) ? $clog2(poll_gap_p + 1) : 1;

  localparam logic [13:0] buf_base_lp = 14'h0800;
  localparam logic [13:0] ready_lp    = 14'h101C;
  localparam logic [13:0] send_lp     = 14'h1018;
  localparam logic [13:0] len_lp      = 14'h1028;
  localparam logic [13:0] pend_lp     = 14'h1030;
  localparam logic [13:0] irq_en_lp   = 14'h1034;

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic [poll_w_lp-1:0]  poll_q, poll_d;
  logic [7:0]            tail_q, tail_d;
  logic                  err_q, err_d;
  logic [2:0]            nbytes;
  logic [cnt_w_lp:0]     cnt_next;
  logic                  overflow;
  logic                  unused_ok;

  assign unused_ok = ^{read_data_i[data_width_p-1:1], tx_irq_i};

  assign nbytes   = (pkt_last_i && pkt_bytes_i != 2'd0) ? {1'b0, pkt_bytes_i} : 3'd4;
  assign cnt_next = {1'b0, cnt_q} + (cnt_w_lp + 1)'(nbytes);
  assign overflow = cnt_next > (cnt_w_lp + 1)'(eth_mtu_p);

  assign busy_o  = (state_q != IDLE);
  assign error_o = err_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      tail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    poll_d       = poll_q;
    tail_d       = tail_q;
    err_d        = 1'b0;
    pkt_ready_o  = 1'b0;
    addr_o       = '0;
    write_en_o   = 1'b0;
    read_en_o    = 1'b0;
    op_size_o    = 2'd0;
    write_data_o = '0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        poll_d = '0;
        if (pkt_v_i) state_d = RDY_RD;
      end
      RDY_RD, PEND_RD: begin
        read_en_o = 1'b1;
        op_size_o = 2'd2;
        addr_o    = (state_q == RDY_RD) ? ready_lp : pend_lp;
        state_d   = (state_q == RDY_RD) ? RDY_CHK : PEND_CHK;
      end
      RDY_CHK, PEND_CHK: begin
        if (read_data_i[0]) begin
`ifdef ETH_MMIO_TX_INIT_IRQ_EN
          state_d = (state_q == RDY_CHK) ? EN_IRQ : CLR;
`else
          state_d = (state_q == RDY_CHK) ? DATA : CLR;
`endif
        end else if (poll_gap_p > 1) begin
          // the check cycle itself counts as the first gap cycle
          poll_d  = poll_w_lp'(poll_gap_p - 2);
          state_d = (state_q == RDY_CHK) ? RDY_WAIT : PEND_WAIT;
        end else begin
          state_d = (state_q == RDY_CHK) ? RDY_RD : PEND_RD;
        end
      end
      RDY_WAIT, PEND_WAIT: begin
        if (poll_q == '0) state_d = (state_q == RDY_WAIT) ? RDY_RD : PEND_RD;
        else              poll_d  = poll_q - poll_w_lp'(1);
      end
      EN_IRQ: begin
        write_en_o   = 1'b1;
        op_size_o    = 2'd2;
        addr_o       = irq_en_lp;
        write_data_o = data_width_p'(1);
        state_d      = DATA;
      end
      DATA: begin
        pkt_ready_o = 1'b1;
        if (pkt_v_i) begin
          if (overflow) begin
            state_d = pkt_last_i ? IDLE : DROP;
            err_d   = pkt_last_i;
          end else begin
            write_en_o   = 1'b1;
            addr_o       = buf_base_lp + 14'(cnt_q);
            op_size_o    = 2'd2;
            write_data_o = data_width_p'(pkt_data_i);
            cnt_d        = cnt_next[cnt_w_lp-1:0];
            if (pkt_last_i) begin
              state_d = LEN;
              unique case (pkt_bytes_i)
                2'd1: begin
                  op_size_o    = 2'd0;
                  write_data_o = data_width_p'(pkt_data_i[7:0]);
                end
                2'd2: begin
                  op_size_o    = 2'd1;
                  write_data_o = data_width_p'(pkt_data_i[15:0]);
                end
                2'd3: begin
                  op_size_o    = 2'd1;
                  write_data_o = data_width_p'(pkt_data_i[15:0]);
                  tail_d       = pkt_data_i[23:16];
                  cnt_d        = cnt_q + cnt_w_lp'(2);
                  state_d      = DATA_TAIL;
                end
                default: ;
              endcase
            end
          end
        end
      end
      DATA_TAIL: begin
        write_en_o   = 1'b1;
        addr_o       = buf_base_lp + 14'(cnt_q);
        op_size_o    = 2'd0;
        write_data_o = data_width_p'(tail_q);
        cnt_d        = cnt_q + cnt_w_lp'(1);
        state_d      = LEN;
      end
      LEN: begin
        write_en_o   = 1'b1;
        addr_o       = len_lp;
        op_size_o    = 2'd2;
        write_data_o = data_width_p'(cnt_q);
        state_d      = SEND;
      end
      SEND: begin
        write_en_o   = 1'b1;
        addr_o       = send_lp;
        op_size_o    = 2'd2;
        write_data_o = data_width_p'(1);
`ifdef ETH_MMIO_TX_INIT_IRQ_EN
        state_d      = WAIT_IRQ;
`else
        state_d      = PEND_RD;
`endif
      end
      WAIT_IRQ: begin
        if (tx_irq_i) state_d = CLR;
      end
      CLR: begin
        write_en_o   = 1'b1;
        addr_o       = pend_lp;
        op_size_o    = 2'd2;
        write_data_o = data_width_p'(1);
        done_o       = 1'b1;
        state_d      = IDLE;
      end
      DROP: begin
        pkt_ready_o = 1'b1;
        if (pkt_v_i && pkt_last_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // a rejected access aborts; mid-packet the remaining words are drained first
    if ((write_en_o || read_en_o) && io_decode_error_i) begin
      done_o = 1'b0;
      if (state_q == DATA && !pkt_last_i) begin
        state_d = DROP;
        err_d   = 1'b0;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_tx_initiator.sv
// Directed bench for ethernet_mmio_tx_initiator: acts as the MMIO target and logs every strobe.
module tb_ethernet_mmio_tx_initiator;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        pkt_v_i, pkt_ready_o, pkt_last_i;
  logic [31:0] pkt_data_i;
  logic [1:0]  pkt_bytes_i;
  logic [13:0] addr_o;
  logic        write_en_o, read_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o, read_data_i;
  logic        io_decode_error_i, tx_irq_i;
  logic        busy_o, done_o, error_o;

  ethernet_mmio_tx_initiator #(.eth_mtu_p(2048), .data_width_p(32), .poll_gap_p(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .pkt_v_i(pkt_v_i), .pkt_ready_o(pkt_ready_o), .pkt_data_i(pkt_data_i),
    .pkt_last_i(pkt_last_i), .pkt_bytes_i(pkt_bytes_i),
    .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
    .op_size_o(op_size_o), .write_data_o(write_data_o), .read_data_i(read_data_i),
    .io_decode_error_i(io_decode_error_i), .tx_irq_i(tx_irq_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          we;
    logic [13:0] addr;
    logic [1:0]  op;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        log_q[$];
  bit          ready_q[$];
  bit          pend_q[$];
  int          cyc = 0;
  int          done_cnt = 0, err_cnt = 0, both_cnt = 0;
  bit          err_armed = 0;
  logic [13:0] err_addr = '0;
  int          checks = 0, errors = 0;

  always @(posedge clk_i) cyc++;

  // strobe monitor plus MMIO target: read data for the next cycle, decode error in the same cycle
  always @(negedge clk_i) begin
    if (write_en_o || read_en_o)
      log_q.push_back('{we: write_en_o, addr: addr_o, op: op_size_o, data: write_data_o, cyc: cyc});
    if (write_en_o && read_en_o) both_cnt++;
    if (done_o === 1'b1) done_cnt++;
    if (error_o === 1'b1) err_cnt++;
    if (read_en_o) begin
      if (addr_o == 14'h101C) read_data_i = (ready_q.size() > 0) ? 32'(ready_q.pop_front()) : 32'd1;
      else if (addr_o == 14'h1030) read_data_i = (pend_q.size() > 0) ? 32'(pend_q.pop_front()) : 32'd1;
      else read_data_i = 32'd0;
    end
    if (err_armed && (write_en_o || read_en_o) && addr_o == err_addr) begin
      io_decode_error_i = 1'b1;
      err_armed = 0;
    end else begin
      io_decode_error_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input bit we, input logic [13:0] a, input logic [1:0] op,
                                     input logic [31:0] d);
    return {15'd0, we, a, op, d};
  endfunction

  task automatic chk_acc(input string tag, input int i, input bit we, input logic [13:0] a,
                         input logic [1:0] op, input logic [31:0] d);
    acc_t e;
    if (i < log_q.size()) e = log_q[i];
    else e = '{we: 1'b0, addr: 14'h3FFF, op: 2'd3, data: 32'hDEAD_BEEF, cyc: -1};
    chk(tag, pk(e.we, e.addr, e.op, e.data), pk(we, a, op, d));
  endtask

  int tmo = 0;

  task automatic push_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int n = 0;
    pkt_v_i = 1'b1; pkt_data_i = d; pkt_last_i = last; pkt_bytes_i = nb;
    @(negedge clk_i);
    while (!pkt_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!pkt_ready_o) tmo++;
    @(posedge clk_i); #1;
    pkt_v_i = 1'b0; pkt_last_i = 1'b0; pkt_bytes_i = 2'd0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    int d0 = done_cnt;
    int e0 = err_cnt;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    chk({tag, "_tmo"}, 64'(n < 300 && tmo == 0), 64'd1);
    tmo = 0;
  endtask

  task automatic new_test();
    @(posedge clk_i); #1;
    log_q.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  function automatic int count_addr(input logic [13:0] a);
    int c = 0;
    foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == a) c++;
    return c;
  endfunction

  initial begin
    reset_ni = 1'b0;
    pkt_v_i = 1'b0; pkt_data_i = '0; pkt_last_i = 1'b0; pkt_bytes_i = '0;
    read_data_i = '0; io_decode_error_i = 1'b0; tx_irq_i = 1'b0;
    #1;
    chk("reset_outputs", 64'({pkt_ready_o, addr_o, write_en_o, read_en_o, op_size_o,
                              write_data_o, busy_o, done_o, error_o}), 64'd0);
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;

    // 8-byte packet, ready on first poll
    new_test();
    push_word(32'h4433_2211, 1'b0, 2'd0);
    push_word(32'h8877_6655, 1'b1, 2'd0);
    wait_end("p8");
    chk("p8_n", 64'(log_q.size()), 64'd7);
    chk_acc("p8_rdy", 0, 1'b0, 14'h101C, 2'd2, 32'h0);
    chk_acc("p8_w0",  1, 1'b1, 14'h0800, 2'd2, 32'h4433_2211);
    chk_acc("p8_w1",  2, 1'b1, 14'h0804, 2'd2, 32'h8877_6655);
    chk_acc("p8_len", 3, 1'b1, 14'h1028, 2'd2, 32'd8);
    chk_acc("p8_snd", 4, 1'b1, 14'h1018, 2'd2, 32'd1);
    chk_acc("p8_pnd", 5, 1'b0, 14'h1030, 2'd2, 32'h0);
    chk_acc("p8_clr", 6, 1'b1, 14'h1030, 2'd2, 32'd1);
    chk("p8_done", 64'(done_cnt), 64'd1);
    chk("p8_err", 64'(err_cnt), 64'd0);
    chk("p8_idle", 64'(busy_o), 64'd0);

    // 7-byte packet, 3-byte tail split into halfword + byte
    new_test();
    push_word(32'hDDCC_BBAA, 1'b0, 2'd0);
    push_word(32'h0033_2211, 1'b1, 2'd3);
    wait_end("p7");
    chk("p7_n", 64'(log_q.size()), 64'd8);
    chk_acc("p7_w0",  1, 1'b1, 14'h0800, 2'd2, 32'hDDCC_BBAA);
    chk_acc("p7_w1",  2, 1'b1, 14'h0804, 2'd1, 32'h0000_2211);
    chk_acc("p7_w2",  3, 1'b1, 14'h0806, 2'd0, 32'h0000_0033);
    chk_acc("p7_len", 4, 1'b1, 14'h1028, 2'd2, 32'd7);
    chk("p7_done", 64'(done_cnt), 64'd1);

    // ready 0,0,1 and pending 0,1: polls 5 cycles apart
    new_test();
    ready_q = '{1'b0, 1'b0, 1'b1};
    pend_q  = '{1'b0, 1'b1};
    push_word(32'hCAFE_F00D, 1'b1, 2'd0);
    wait_end("poll");
    chk("poll_n", 64'(log_q.size()), 64'd9);
    chk_acc("poll_r0", 0, 1'b0, 14'h101C, 2'd2, 32'h0);
    chk_acc("poll_r1", 1, 1'b0, 14'h101C, 2'd2, 32'h0);
    chk_acc("poll_r2", 2, 1'b0, 14'h101C, 2'd2, 32'h0);
    chk_acc("poll_w0", 3, 1'b1, 14'h0800, 2'd2, 32'hCAFE_F00D);
    chk_acc("poll_len", 4, 1'b1, 14'h1028, 2'd2, 32'd4);
    chk_acc("poll_p1", 7, 1'b0, 14'h1030, 2'd2, 32'h0);
    if (log_q.size() >= 9) begin
      chk("poll_gap01", 64'(log_q[1].cyc - log_q[0].cyc), 64'd5);
      chk("poll_gap12", 64'(log_q[2].cyc - log_q[1].cyc), 64'd5);
      chk("pend_gap",   64'(log_q[7].cyc - log_q[6].cyc), 64'd5);
    end
    chk("poll_done", 64'(done_cnt), 64'd1);

    // 2052 bytes against a 2048-byte MTU
    new_test();
    for (int i = 0; i < 513; i++) push_word(32'h1000_0000 + 32'(i), i == 512, 2'd0);
    wait_end("ovf");
    chk("ovf_buf_writes", 64'(log_q.size()), 64'd513);
    chk_acc("ovf_last", 512, 1'b1, 14'h0FFC, 2'd2, 32'h1000_01FF);
    chk("ovf_len", 64'(count_addr(14'h1028)), 64'd0);
    chk("ovf_snd", 64'(count_addr(14'h1018)), 64'd0);
    chk("ovf_err", 64'(err_cnt), 64'd1);
    chk("ovf_done", 64'(done_cnt), 64'd0);
    chk("ovf_idle", 64'(busy_o), 64'd0);

    // decode error on the length write
    new_test();
    err_addr = 14'h1028; err_armed = 1;
    push_word(32'h0BAD_0001, 1'b1, 2'd0);
    wait_end("derr");
    chk("derr_err", 64'(err_cnt), 64'd1);
    chk("derr_snd", 64'(count_addr(14'h1018)), 64'd0);
    chk("derr_done", 64'(done_cnt), 64'd0);
    chk("derr_idle", 64'(busy_o), 64'd0);

    // decode error on a mid-packet buffer write: remaining words are drained
    new_test();
    err_addr = 14'h0804; err_armed = 1;
    push_word(32'hA0A0_A0A0, 1'b0, 2'd0);
    push_word(32'hB1B1_B1B1, 1'b0, 2'd0);
    push_word(32'hC2C2_C2C2, 1'b1, 2'd0);
    wait_end("drop");
    chk("drop_n", 64'(log_q.size()), 64'd3);
    chk("drop_err", 64'(err_cnt), 64'd1);
    chk("drop_len", 64'(count_addr(14'h1028)), 64'd0);
    chk("drop_idle", 64'(busy_o), 64'd0);

    // async reset in the middle of DATA
    new_test();
    push_word(32'h1111_1111, 1'b0, 2'd0);
    push_word(32'h2222_2222, 1'b0, 2'd0);
    pkt_v_i = 1'b1; pkt_data_i = 32'h3333_3333; pkt_last_i = 1'b0;
    #1;
    chk("rst_pre_we", pk(write_en_o, addr_o, op_size_o, write_data_o),
        pk(1'b1, 14'h0808, 2'd2, 32'h3333_3333));
    reset_ni = 1'b0;
    #1;
    chk("rst_outputs", 64'({pkt_ready_o, addr_o, write_en_o, read_en_o, op_size_o,
                            write_data_o, busy_o, done_o, error_o}), 64'd0);
    pkt_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    new_test();
    push_word(32'h1234_5678, 1'b1, 2'd0);
    wait_end("rst");
    chk_acc("rst_w0",  1, 1'b1, 14'h0800, 2'd2, 32'h1234_5678);
    chk_acc("rst_len", 2, 1'b1, 14'h1028, 2'd2, 32'd4);
    chk("rst_done", 64'(done_cnt), 64'd1);

    chk("no_dual_strobe", 64'(both_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
